// File: rtl/spi_mac_slave.sv
`timescale 1ns/1ps
// spi_mac_slave
//   SPI slave (oversampled on clk) fronting a coefficient bank, a sample bank
//   and a sequential multiply-accumulate engine. Frames are MSB first:
//   RW, BANK, ADDR[ADDR_W-1:0], DATA[DATA_W-1:0]. A start request computes
//   sum(coef[i]*sample[i]), rounds/truncates FRAC_W bits and saturates.
//
// Ports
//   clk        system clock (>= 8x SPI_clk)
//   rst        asynchronous reset, active-high
//   SPI_clk    serial clock, async to clk
//   SPI_en     chip select, active-low
//   SPI_data   MOSI, sampled on SPI_clk rising edge
//   SPI_RD     MISO, updated after SPI_clk falling edge
//   aluop_st   MAC start level, sampled every clk while idle
//   round_mode 0 = truncate, 1 = round half-up (latched with aluop_st)
//   mac_busy   MAC engine running
//   mac_done   one-cycle pulse when result updates
//   result     last saturated MAC result
//   wr_drop    one-cycle pulse when a write frame is discarded (MAC busy)
module spi_mac_slave #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 19,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     SPI_clk,
  input  logic                     SPI_en,
  input  logic                     SPI_data,
  output logic                     SPI_RD,
  input  logic                     aluop_st,
  input  logic                     round_mode,
  output logic                     mac_busy,
  output logic                     mac_done,
  output logic signed [DATA_W-1:0] result,
  output logic                     wr_drop
);

  localparam int FRAME_LEN = 2 + ADDR_W + DATA_W;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_W     = 2 * DATA_W + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int RDC_W     = $clog2(DATA_W + 1);
  localparam int HDR_LAST  = 1 + ADDR_W;

  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(longint'(1) << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a,
    input logic                    rm
  );
    logic signed [ACC_W-1:0] t;
    t = rm ? (a + HALF_LSB) : a;
    return t >>> FRAC_W;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(
    input logic signed [ACC_W-1:0] v
  );
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2 keeps SPI_clk history for edges
  logic spi_clk_p0, spi_clk_p1, spi_clk_p2;
  logic spi_en_p0, spi_en_p1;
  logic spi_data_p0, spi_data_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_clk_p0  <= 1'b0;
      spi_clk_p1  <= 1'b0;
      spi_clk_p2  <= 1'b0;
      spi_en_p0   <= 1'b1;
      spi_en_p1   <= 1'b1;
      spi_data_p0 <= 1'b0;
      spi_data_p1 <= 1'b0;
    end else begin
      spi_clk_p0  <= SPI_clk;
      spi_clk_p1  <= spi_clk_p0;
      spi_clk_p2  <= spi_clk_p1;
      spi_en_p0   <= SPI_en;
      spi_en_p1   <= spi_en_p0;
      spi_data_p0 <= SPI_data;
      spi_data_p1 <= spi_data_p0;
    end
  end

  logic sclk_rise, sclk_fall;
  assign sclk_rise = spi_clk_p1 & ~spi_clk_p2;
  assign sclk_fall = ~spi_clk_p1 & spi_clk_p2;

  logic [CNT_W-1:0]          bit_cnt;
  logic [FRAME_LEN-1:0]      shreg;
  logic [FRAME_LEN-1:0]      shreg_nxt;
  logic                      commit_p;
  logic                      rd_act;
  logic [RDC_W-1:0]          rd_cnt;
  logic [DATA_W-1:0]         snap;
  logic signed [DATA_W-1:0]  coef [DEPTH];
  logic signed [DATA_W-1:0]  samp [DEPTH];

  assign shreg_nxt = {shreg[FRAME_LEN-2:0], spi_data_p1};

  // Header fields as seen at the edge capturing the last address bit
  logic              hdr_rw, hdr_bank;
  logic [ADDR_W-1:0] hdr_addr;
  assign hdr_rw   = shreg_nxt[HDR_LAST];
  assign hdr_bank = shreg_nxt[ADDR_W];
  assign hdr_addr = shreg_nxt[ADDR_W-1:0];

  // Fields of a completed frame, used in the commit cycle
  logic                     wr_rw, wr_bank;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  assign wr_rw   = shreg[FRAME_LEN-1];
  assign wr_bank = shreg[FRAME_LEN-2];
  assign wr_addr = shreg[DATA_W+ADDR_W-1:DATA_W];
  assign wr_data = shreg[DATA_W-1:0];

  // Stage frame: bit capture, read snapshot and MISO shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      commit_p <= 1'b0;
      rd_act   <= 1'b0;
      rd_cnt   <= '0;
      snap     <= '0;
      SPI_RD   <= 1'b0;
    end else begin
      commit_p <= 1'b0;
      if (spi_en_p1) begin
        bit_cnt <= '0;
        rd_act  <= 1'b0;
        rd_cnt  <= '0;
        SPI_RD  <= 1'b0;
      end else begin
        if (sclk_rise && bit_cnt < CNT_W'(FRAME_LEN)) begin
          shreg   <= shreg_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(FRAME_LEN - 1))
            commit_p <= 1'b1;
          // Result snapshot uses the pre-update value if ROUND fires now
          if (bit_cnt == CNT_W'(HDR_LAST) && hdr_rw) begin
            snap   <= hdr_bank ? result : coef[hdr_addr];
            rd_act <= 1'b1;
            rd_cnt <= '0;
          end
        end
        if (sclk_fall && rd_act) begin
          if (rd_cnt < RDC_W'(DATA_W)) begin
            SPI_RD <= snap[DATA_W-1];
            snap   <= {snap[DATA_W-2:0], 1'b0};
            rd_cnt <= rd_cnt + 1'b1;
          end else begin
            SPI_RD <= 1'b0;
          end
        end
      end
    end
  end

  // Stage commit: register-file write or drop, one cycle after last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        coef[i] <= '0;
        samp[i] <= '0;
      end
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= 1'b0;
      if (commit_p && !wr_rw) begin
        if (mac_busy)     wr_drop       <= 1'b1;
        else if (wr_bank) samp[wr_addr] <= wr_data;
        else              coef[wr_addr] <= wr_data;
      end
    end
  end

  logic [1:0]               state;
  logic [ADDR_W-1:0]        idx;
  logic signed [ACC_W-1:0]  acc;
  logic                     rmode;
  logic signed [PROD_W-1:0] prod_p0;

  assign prod_p0 = PROD_W'(coef[idx]) * PROD_W'(samp[idx]);

  // Stage mac: IDLE -> ACC (DEPTH cycles) -> ROUND -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc      <= '0;
      rmode    <= 1'b0;
      mac_busy <= 1'b0;
      mac_done <= 1'b0;
      result   <= '0;
    end else begin
      mac_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (aluop_st) begin
            rmode    <= round_mode;
            acc      <= '0;
            idx      <= '0;
            mac_busy <= 1'b1;
            state    <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= acc + ACC_W'(prod_p0);
          idx <= idx + 1'b1;
          if (idx == ADDR_W'(DEPTH - 1))
            state <= S_ROUND;
        end
        S_ROUND: begin
          result   <= saturate(round_shift(acc, rmode));
          mac_done <= 1'b1;
          mac_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mac_slave.sv
`timescale 1ns/1ps
// Bench for spi_mac_slave: SPI frames driven bit by bit from clk edges,
// MAC results compared against table constants and an arithmetic model.
module tb_spi_mac_slave;

  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 19;
  localparam int FRAC_W    = 8;
  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 24;
  localparam int HALF      = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              SPI_clk, SPI_en, SPI_data, SPI_RD;
  logic              aluop_st, round_mode;
  logic              mac_busy, mac_done, wr_drop;
  logic [DATA_W-1:0] result;

  spi_mac_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .SPI_clk(SPI_clk), .SPI_en(SPI_en),
    .SPI_data(SPI_data), .SPI_RD(SPI_RD), .aluop_st(aluop_st),
    .round_mode(round_mode), .mac_busy(mac_busy), .mac_done(mac_done),
    .result(result), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int drop_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    if (wr_drop)  drop_cnt <= drop_cnt + 1;
    if (mac_done) done_cnt <= done_cnt + 1;
  end

  logic [DATA_W-1:0] coef_m [DEPTH];
  logic [DATA_W-1:0] samp_m [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Dot product, floor division by 2**FRAC_W, clamp to the signed range
  function automatic logic [DATA_W-1:0] mac_model(input logic rm);
    longint sum, c, s, r, q;
    sum = 0;
    for (int i = 0; i < DEPTH; i++) begin
      c = longint'($signed(coef_m[i]));
      s = longint'($signed(samp_m[i]));
      sum += c * s;
    end
    if (rm) sum += longint'(1) << (FRAC_W - 1);
    r = sum % 256;
    if (r < 0) r += 256;
    q = (sum - r) / 256;
    if (q > 262143)  q = 262143;
    if (q < -262144) q = -262144;
    return q[DATA_W-1:0];
  endfunction

  task automatic spi_bit(input logic b, input logic pulse, output logic rd);
    @(negedge clk);
    SPI_clk  = 1'b0;
    SPI_data = b;
    repeat (HALF - 1) @(negedge clk);
    rd = SPI_RD;
    @(negedge clk);
    SPI_clk = 1'b1;
    if (pulse) begin
      aluop_st   = 1'b1;
      round_mode = 1'b0;
    end
    @(negedge clk);
    aluop_st = 1'b0;
    repeat (HALF - 2) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [FRAME_LEN-1:0] fr, input int nbits,
                           input logic pulse_last, output logic [DATA_W-1:0] rd_word);
    logic rd;
    rd_word = '0;
    @(negedge clk);
    SPI_en = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      spi_bit(fr[FRAME_LEN-1-k], pulse_last && (k == nbits - 1), rd);
      if (k >= 5) rd_word[FRAME_LEN-1-k] = rd;
      else        check("miso_hdr", {31'd0, rd}, 32'd0);
    end
    @(negedge clk);
    SPI_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("miso_tail", {31'd0, SPI_RD}, 32'd0);
    SPI_en = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic write_word(input logic bank, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic pulse, input logic dropped);
    logic [DATA_W-1:0] rw;
    spi_frame({1'b0, bank, addr, data}, FRAME_LEN, pulse, rw);
    check("miso_wr", {13'd0, rw}, 32'd0);
    if (!dropped) begin
      if (bank) samp_m[addr] = data;
      else      coef_m[addr] = data;
    end
  endtask

  task automatic read_word(input logic bank, input logic [ADDR_W-1:0] addr,
                           output logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] junk;
    junk = DATA_W'($urandom);
    spi_frame({1'b1, bank, addr, junk}, FRAME_LEN, 1'b0, data);
  endtask

  task automatic run_mac(input logic rm, input logic [DATA_W-1:0] exp, input string name);
    int n;
    @(negedge clk);
    aluop_st   = 1'b1;
    round_mode = rm;
    @(posedge clk);
    #1 check("busy_rise", {31'd0, mac_busy}, 32'd1);
    @(negedge clk);
    aluop_st = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!mac_done && n < 40);
    check("mac_latency", n, DEPTH + 1);
    check(name, {13'd0, result}, {13'd0, exp});
    check("busy_fall", {31'd0, mac_busy}, 32'd0);
  endtask

  typedef struct {
    logic [DATA_W-1:0] c0;
    logic [DATA_W-1:0] s0;
    logic              rm;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rw;
    logic [DATA_W-1:0] old;
    logic [ADDR_W-1:0] a;
    logic              rm, rd;
    int                d0, c0, v;

    tbl[0] = '{19'h00100, 19'h00303, 1'b0, 19'h00303};
    tbl[1] = '{19'h00180, 19'h00101, 1'b0, 19'h00181};
    tbl[2] = '{19'h00180, 19'h00101, 1'b1, 19'h00182};
    tbl[3] = '{19'h7FF00, 19'h00101, 1'b0, 19'h7FEFF};
    tbl[4] = '{19'h7FF00, 19'h00101, 1'b1, 19'h7FEFF};
    tbl[5] = '{19'h40000, 19'h3FFFF, 1'b0, 19'h40000};

    for (int i = 0; i < DEPTH; i++) begin
      coef_m[i] = '0;
      samp_m[i] = '0;
    end

    rst = 1'b1; SPI_clk = 1'b0; SPI_en = 1'b1; SPI_data = 1'b0;
    aluop_st = 1'b0; round_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", {13'd0, result}, 32'd0);
    check("rst_busy", {31'd0, mac_busy}, 32'd0);
    check("rst_done", {31'd0, mac_done}, 32'd0);
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    check("rst_miso", {31'd0, SPI_RD}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed MAC vectors; only word 0 of each bank is non-zero
    for (int i = 0; i < 6; i++) begin
      write_word(1'b0, 3'd0, tbl[i].c0, 1'b0, 1'b0);
      write_word(1'b1, 3'd0, tbl[i].s0, 1'b0, 1'b0);
      run_mac(tbl[i].rm, tbl[i].exp, "tbl_result");
      read_word(1'b1, ADDR_W'($urandom), rw);
      check("tbl_rd_result", {13'd0, rw}, {13'd0, tbl[i].exp});
    end

    // Positive saturation
    for (int i = 0; i < DEPTH; i++) begin
      write_word(1'b0, ADDR_W'(i), 19'h3FFFF, 1'b0, 1'b0);
      write_word(1'b1, ADDR_W'(i), 19'h3FFFF, 1'b0, 1'b0);
    end
    run_mac(1'b0, 19'h3FFFF, "sat_pos");

    // Coefficient read-back window
    write_word(1'b0, 3'd5, 19'h2A5C3, 1'b0, 1'b0);
    read_word(1'b0, 3'd5, rw);
    check("rd_coef5", {13'd0, rw}, 32'h2A5C3);

    // Write committing while the MAC runs is dropped
    d0  = drop_cnt;
    c0  = done_cnt;
    old = coef_m[3];
    write_word(1'b0, 3'd3, 19'h12345, 1'b1, 1'b1);
    check("drop_pulses", drop_cnt - d0, 1);
    check("drop_mac_done", done_cnt - c0, 1);
    check("drop_result", {13'd0, result}, {13'd0, mac_model(1'b0)});
    read_word(1'b0, 3'd3, rw);
    check("drop_word_kept", {13'd0, rw}, {13'd0, old});

    // Aborted partial write frame has no effect
    d0 = drop_cnt;
    spi_frame({1'b0, 1'b0, 3'd3, 19'h00777}, 10, 1'b0, rw);
    check("partial_nodrop", drop_cnt - d0, 0);
    read_word(1'b0, 3'd3, rw);
    check("partial_word_kept", {13'd0, rw}, {13'd0, coef_m[3]});

    // Randomized banks against the model
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < 2; b++) begin
          if (it == 0) v = int'($urandom);
          else         v = int'($urandom_range(0, 2047)) - 1024;
          write_word(b[0], ADDR_W'(i), DATA_W'(v), 1'b0, 1'b0);
        end
      end
      rm = 1'($urandom);
      run_mac(rm, mac_model(rm), "rand_result");
      read_word(1'b1, ADDR_W'($urandom), rw);
      check("rand_rd_result", {13'd0, rw}, {13'd0, mac_model(rm)});
      a = ADDR_W'($urandom);
      read_word(1'b0, a, rw);
      check("rand_rd_coef", {13'd0, rw}, {13'd0, coef_m[a]});
    end

    // Reset in the middle of a frame and during ACC
    @(negedge clk);
    SPI_en = 1'b0;
    for (int k = 0; k < 6; k++) spi_bit(1'($urandom), 1'b0, rd);
    @(negedge clk);
    aluop_st = 1'b1;
    round_mode = 1'b0;
    @(negedge clk);
    aluop_st = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, mac_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_result", {13'd0, result}, 32'd0);
    check("mid_rst_busy", {31'd0, mac_busy}, 32'd0);
    check("mid_rst_done", {31'd0, mac_done}, 32'd0);
    check("mid_rst_miso", {31'd0, SPI_RD}, 32'd0);
    check("mid_rst_drop", {31'd0, wr_drop}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      coef_m[i] = '0;
      samp_m[i] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    SPI_en = 1'b1;
    SPI_clk = 1'b0;
    repeat (4) @(negedge clk);
    read_word(1'b0, 3'd0, rw);
    check("post_rst_coef0", {13'd0, rw}, 32'd0);
    write_word(1'b0, 3'd2, 19'h0ABCD, 1'b0, 1'b0);
    write_word(1'b1, 3'd2, 19'h00200, 1'b0, 1'b0);
    read_word(1'b0, 3'd2, rw);
    check("post_rst_coef2", {13'd0, rw}, 32'h0ABCD);
    run_mac(1'b1, 19'h1579A, "post_rst_result");
    read_word(1'b1, 3'd0, rw);
    check("post_rst_rd_result", {13'd0, rw}, {13'd0, mac_model(1'b1)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
